// File: rtl/bsg_vanilla_pkg.sv
// Shared vanilla-core ISA types.
//   instruction_s        : RV32 instruction word, R-type field view
//   vanilla_nop_instr_gp : canonical NOP (addi x0,x0,0)
package bsg_vanilla_pkg;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] op;
  } instruction_s;

  localparam instruction_s vanilla_nop_instr_gp = 32'h0000_0013;

endpackage

// File: rtl/dual_issue_fetch_buffer_pkg.sv
// Local types for the dual-issue fetch buffer.
//   pop_e : number of entries retired on an issue handshake
package dual_issue_fetch_buffer_pkg;

  typedef enum logic [1:0] {
    PopNone = 2'd0,
    PopOne  = 2'd1,
    PopTwo  = 2'd2
  } pop_e;

endpackage

// File: rtl/dual_issue_fetch_buffer_if.sv
// Fetch-side push and decode-side issue handshakes of the fetch buffer.
//   master : driven by the fetch/decode environment
//   slave  : used by the buffer itself
// Slot index 0 is the oldest entry, slot 1 the next one in program order.
interface dual_issue_fetch_buffer_if
  import bsg_vanilla_pkg::*;
#(
  parameter int unsigned pc_width_p = 22
) ();

  logic                         fetch_v;
  instruction_s                 fetch_instr;
  logic [pc_width_p-1:0]        fetch_pc;
  logic                         fetch_ready;

  logic [1:0]                   issue_v;
  instruction_s [0:1]           issue_instr;
  logic [0:1][pc_width_p-1:0]   issue_pc;
  logic                         issue_ready;
  logic                         do_single_issue;

  modport master (
    output fetch_v, fetch_instr, fetch_pc, issue_ready, do_single_issue,
    input  fetch_ready, issue_v, issue_instr, issue_pc
  );

  modport slave (
    input  fetch_v, fetch_instr, fetch_pc, issue_ready, do_single_issue,
    output fetch_ready, issue_v, issue_instr, issue_pc
  );

endinterface

// File: rtl/fetch_buffer_mem_2r1w.sv
// Flop array of {instr, pc} entries: one synchronous write port, two
// asynchronous read ports (used for head and head+1).
//   clk_i                 : clock
//   w_v_i/w_addr_i        : write enable / address
//   w_instr_i/w_pc_i      : write data
//   r0_addr_i/r1_addr_i   : read addresses
//   r0_*_o/r1_*_o         : read data
// Storage has no reset; occupancy tracking in the parent guards every read.
module fetch_buffer_mem_2r1w
  import bsg_vanilla_pkg::*;
#(
  parameter int unsigned els_p      = 4,
  parameter int unsigned pc_width_p = 22,
  localparam int unsigned ptr_w     = $clog2(els_p)
) (
  input  logic                  clk_i,
  input  logic                  w_v_i,
  input  logic [ptr_w-1:0]      w_addr_i,
  input  instruction_s          w_instr_i,
  input  logic [pc_width_p-1:0] w_pc_i,
  input  logic [ptr_w-1:0]      r0_addr_i,
  input  logic [ptr_w-1:0]      r1_addr_i,
  output instruction_s          r0_instr_o,
  output logic [pc_width_p-1:0] r0_pc_o,
  output instruction_s          r1_instr_o,
  output logic [pc_width_p-1:0] r1_pc_o
);

  instruction_s          instr_q [els_p];
  logic [pc_width_p-1:0] pc_q    [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      instr_q[w_addr_i] <= w_instr_i;
      pc_q[w_addr_i]    <= w_pc_i;
    end
  end

  assign r0_instr_o = instr_q[r0_addr_i];
  assign r0_pc_o    = pc_q[r0_addr_i];
  assign r1_instr_o = instr_q[r1_addr_i];
  assign r1_pc_o    = pc_q[r1_addr_i];

endmodule

// File: rtl/dual_issue_fetch_buffer.sv
// Instruction pair buffer feeding the dual-issue decoder. Accepts one fetched
// instruction per cycle, keeps up to els_p entries in program order and
// presents the two oldest as an issue pair; retires one or two per issue.
//   clk_i     : clock
//   reset_n_i : synchronous active-low reset
//   flush_i   : PC redirect, discards all contents
//   bus       : fetch push + issue pair handshakes (slave side)
//   count_o   : current occupancy
module dual_issue_fetch_buffer
  import bsg_vanilla_pkg::*;
  import dual_issue_fetch_buffer_pkg::*;
#(
  parameter int unsigned els_p      = 4,
  parameter int unsigned pc_width_p = 22
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         flush_i,
  dual_issue_fetch_buffer_if.slave     bus,
  output logic [$clog2(els_p+1)-1:0]   count_o
);

  localparam int unsigned ptr_w = $clog2(els_p);
  localparam int unsigned cnt_w = $clog2(els_p+1);

  logic [ptr_w-1:0] head_q, head_d, tail_q, tail_d, head_p1;
  logic [cnt_w-1:0] count_q, count_d;

  instruction_s          r0_instr, r1_instr;
  logic [pc_width_p-1:0] r0_pc, r1_pc, pc_succ;
  logic [1:0]            slot_v;
  logic                  push;
  pop_e                  pop;
  logic [1:0]            pop_num;

  // Ready depends only on occupancy, so a full buffer refuses a push even
  // in a cycle where it also pops.
  assign bus.fetch_ready = reset_n_i & (count_q < cnt_w'(els_p));
  assign push            = bus.fetch_v & bus.fetch_ready & ~flush_i;
  assign head_p1         = head_q + ptr_w'(1);

  fetch_buffer_mem_2r1w #(
    .els_p      (els_p),
    .pc_width_p (pc_width_p)
  ) u_mem (
    .clk_i      (clk_i),
    .w_v_i      (push),
    .w_addr_i   (tail_q),
    .w_instr_i  (bus.fetch_instr),
    .w_pc_i     (bus.fetch_pc),
    .r0_addr_i  (head_q),
    .r1_addr_i  (head_p1),
    .r0_instr_o (r0_instr),
    .r0_pc_o    (r0_pc),
    .r1_instr_o (r1_instr),
    .r1_pc_o    (r1_pc)
  );

  // Only pair sequential PCs; a fetch discontinuity splits the pair.
  assign pc_succ   = r0_pc + pc_width_p'(1);
  assign slot_v[0] = (count_q != '0);
  assign slot_v[1] = (count_q >= cnt_w'(2)) & (r1_pc == pc_succ);

  assign bus.issue_v        = slot_v;
  assign bus.issue_instr[0] = slot_v[0] ? r0_instr : vanilla_nop_instr_gp;
  assign bus.issue_instr[1] = slot_v[1] ? r1_instr : vanilla_nop_instr_gp;
  assign bus.issue_pc[0]    = slot_v[0] ? r0_pc : '0;
  assign bus.issue_pc[1]    = slot_v[1] ? r1_pc : '0;
  assign count_o            = count_q;

  always_comb begin
    pop = PopNone;
    if (bus.issue_ready & slot_v[0]) begin
      pop = (bus.do_single_issue | ~slot_v[1]) ? PopOne : PopTwo;
    end
  end

  assign pop_num = pop;

  always_comb begin
    head_d  = head_q + ptr_w'(pop_num);
    tail_d  = tail_q + ptr_w'(push);
    count_d = count_q + cnt_w'(push) - cnt_w'(pop_num);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
